oam_dma_ctrl: RTL
=================

# oam_dma_ctrl

Sequences the sprite OAM DMA triggered by a CPU write to $4014. It stalls the CPU through the top-level `oam_dma` / `rdy` path, takes the CPU bus, and reads 256 bytes from page `$XX00–$XXFF`. Each byte is written into PPU OAM starting at the current OAMADDR. Total duration is 513 or 514 cycles depending on start parity, matching 2A03 behaviour.

## Interface
Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA
- XFER_LEN, 256, bytes per transfer (power of two, ≤ 256)

Ports:
- clk  in  1  system clock (CPU cycle rate)
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  16  CPU address bus
- cpu_wdata  in  8  CPU write data
- cpu_we  in  1  CPU write strobe for current cycle
- oam_addr_start  in  8  current PPU OAMADDR, sampled at trigger
- mem_rdata  in  8  CPU-space read data, valid the cycle after `mem_rd_en`
- oam_dma  out  1  DMA owns bus; top level drives `rdy = ~oam_dma`
- mem_addr  out  16  DMA read address
- mem_rd_en  out  1  DMA read strobe
- oam_addr  out  8  OAM write address
- oam_data_in  out  8  OAM write data
- oam_we  out  1  OAM write strobe

## Operation
- Free-running parity bit `odd` toggles every clk and resets to 0.
- Internal byte counter `idx` is 8 bits.
- States:
  - IDLE
    - Trigger is `cpu_we && cpu_addr == DMA_REG_ADDR`.
    - On trigger: latch `page <= cpu_wdata`, `base <= oam_addr_start`, `idx <= 0`, go to HALT.
  - HALT
    - One dummy cycle minimum, so the CPU can finish its write.
    - Stay in HALT while `cpu_we` is high, because a 6502 cannot halt on a write cycle.
    - On exit: if `odd == 1`, go to ALIGN; otherwise go to READ.
  - ALIGN: one idle cycle, then READ.
  - READ
    - `mem_addr = {page, idx}`, `mem_rd_en = 1`.
    - Next state is WRITE.
  - WRITE
    - `oam_addr = base + idx` (8-bit wrap), `oam_data_in = mem_rdata`, `oam_we = 1`.
    - `idx <= idx + 1`.
    - If `idx == XFER_LEN-1`, go to IDLE; otherwise go to READ.
- `oam_dma` is high in every state except IDLE. It is registered, so it rises the cycle after the trigger and falls the cycle after the last WRITE.
- Triggers are ignored while not in IDLE; `page` and `base` are not updated.
- Page $FF is legal. `mem_addr` runs $FF00–$FFFF with no wrap into page $00.
- OAM address wraps: with base=$F0, byte 16 lands at $00.
- Outputs not active in the current state are 0: `mem_rd_en`, `oam_we`, `mem_addr`, `oam_addr`, `oam_data_in`.

## Timing
- Reset values:
  - state IDLE; `odd`, `idx`, `page`, `base` = 0.
  - All outputs 0.
  - Reset mid-transfer aborts immediately: next cycle `oam_dma = 0` and no further OAM writes. A partially written OAM is acceptable.
- Trigger in cycle T means HALT occupies cycle T+1.
- Duration, with no CPU write after the trigger:
  - Even start: 1 HALT + 512 READ/WRITE = 513 cycles of `oam_dma` high.
  - Odd start: 1 HALT + 1 ALIGN + 512 = 514 cycles.
- Each extra consecutive `cpu_we` cycle in HALT adds one cycle. Parity is evaluated on the HALT exit cycle.
- Read latency is exactly 1: data from READ at cycle k is written in WRITE at cycle k+1.
- A trigger in the same cycle as the final WRITE is ignored, because the block is not in IDLE. A trigger on the first IDLE cycle afterward is accepted.

## Test plan
- Even-parity start, page $02, base $00, memory[$0200+i]=i^$5A → `oam_dma` high exactly 513 cycles; OAM[i]=i^$5A for all 256; 256 `oam_we` pulses.
- Odd-parity start, page $03 → `oam_dma` high 514 cycles; first `mem_rd_en` is 3 cycles after the trigger cycle.
- base=$F8, page $07 → byte 0 at OAM $F8, byte 8 at OAM $00, byte 255 at OAM $F7.
- Second $4014 write (page $05) injected at cycle 100 of a page-$02 DMA → ignored; all `mem_addr` values stay in $02xx; total length unchanged.
- `cpu_we` held 2 extra cycles after the trigger → HALT lasts 3 cycles; total is 515 or 516 cycles per exit parity.
- Reset asserted at byte 40 → next cycle `oam_dma=0`, `oam_we=0`, state IDLE; a new trigger afterward runs a full 513/514-cycle transfer.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl
//   Sprite OAM DMA sequencer. A CPU write to DMA_REG_ADDR starts a transfer
//   of XFER_LEN bytes from CPU page {page,$00..} into PPU OAM, starting at
//   the OAMADDR value captured at the trigger. The CPU is stalled while
//   oam_dma is high (top level drives rdy = ~oam_dma). A transfer takes
//   one HALT cycle (longer while the CPU keeps writing), an optional ALIGN
//   cycle on odd parity, then alternating READ/WRITE cycles.
//
// Ports
//   clk            system clock, CPU cycle rate
//   reset          synchronous active-high reset
//   cpu_addr       CPU address bus
//   cpu_wdata      CPU write data (page number on trigger)
//   cpu_we         CPU write strobe
//   oam_addr_start current PPU OAMADDR, sampled on trigger
//   mem_rdata      CPU-space read data, valid the cycle after mem_rd_en
//   oam_dma        DMA owns the bus
//   mem_addr       DMA read address
//   mem_rd_en      DMA read strobe
//   oam_addr       OAM write address
//   oam_data_in    OAM write data
//   oam_we         OAM write strobe
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
   parameter int unsigned XFER_LEN     = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_we,
   input  logic [7:0]  oam_addr_start,
   input  logic [7:0]  mem_rdata,
   output logic        oam_dma,
   output logic [15:0] mem_addr,
   output logic        mem_rd_en,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_data_in,
   output logic        oam_we
);

   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   state_t     state;
   logic       odd;
   logic [7:0] idx;
   logic [7:0] page;
   logic [7:0] base;
   logic       trigger;

   assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

   // Outputs are registered on entry to the state that owns them, so they
   // line up exactly with the cycle the FSM spends in that state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         odd       <= 1'b0;
         idx       <= '0;
         page      <= '0;
         base      <= '0;
         oam_dma   <= 1'b0;
         mem_addr  <= '0;
         mem_rd_en <= 1'b0;
         oam_addr  <= '0;
         oam_we    <= 1'b0;
      end else begin
         odd       <= ~odd;
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         oam_we    <= 1'b0;
         oam_addr  <= '0;
         case (state)
            IDLE: begin
               if (trigger) begin
                  page    <= cpu_wdata;
                  base    <= oam_addr_start;
                  idx     <= '0;
                  state   <= HALT;
                  oam_dma <= 1'b1;
               end
            end
            HALT: begin
               // The 6502 cannot halt on a write cycle; parity is judged on
               // the cycle that actually leaves HALT.
               if (!cpu_we) begin
                  if (odd) begin
                     state <= ALIGN;
                  end else begin
                     state     <= READ;
                     mem_rd_en <= 1'b1;
                     mem_addr  <= {page, idx};
                  end
               end
            end
            ALIGN: begin
               state     <= READ;
               mem_rd_en <= 1'b1;
               mem_addr  <= {page, idx};
            end
            READ: begin
               state    <= WRITE;
               oam_we   <= 1'b1;
               oam_addr <= base + idx;
            end
            WRITE: begin
               idx <= idx + 8'd1;
               if (idx == LAST_IDX) begin
                  state   <= IDLE;
                  oam_dma <= 1'b0;
               end else begin
                  state     <= READ;
                  mem_rd_en <= 1'b1;
                  mem_addr  <= {page, idx + 8'd1};
               end
            end
            default: begin
               state   <= IDLE;
               oam_dma <= 1'b0;
            end
         endcase
      end
   end

   // Read data only arrives during WRITE, so it is passed straight through.
   assign oam_data_in = oam_we ? mem_rdata : '0;

endmodule
